// File: rtl/irq_ctrl.sv
// irq_ctrl: CP0-style interrupt controller (SR/Cause/EPC/PRId); define IRQ_EDGE_EN for edge-triggered IP
module irq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hwint,
    input  logic        EXLSet,
    input  logic        EXLClr,
    input  logic        cp0Wr,
    input  logic [4:0]  sel,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic [31:0] epc,
    output logic        irq,
    output logic [2:0]  cause_id
);
    logic [5:0]  im;
    logic [5:0]  ip;
    logic        exl;
    logic        ie;
    logic [29:0] epc_r;
    logic [2:0]  cid;
    logic        unused_ok;
`ifdef IRQ_EDGE_EN
    logic [5:0]  hw_q;
    logic [5:0]  clr;
    assign clr = (EXLSet && cause_id != 3'b111) ? 6'b1 << cause_id : 6'b0;
`endif
    assign unused_ok = ^{wdata[31:16], wdata[9:2], pc[1:0]};
    assign epc = {epc_r, 2'b00};
    assign irq = |(ip & im) & ie & ~exl;
    always_comb begin
        cause_id = 3'b111;
        for (int i = 5; i >= 0; i--)
            if (ip[i] & im[i]) cause_id = 3'(i);
    end
    assign rdata = (sel == 5'd12) ? {16'b0, im, 8'b0, exl, ie} :
                   (sel == 5'd13) ? {16'b0, ip, 5'b0, cid, 2'b0} :
                   (sel == 5'd14) ? epc :
                   (sel == 5'd15) ? 32'h4D49_5053 : 32'h0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im    <= '0;
            ip    <= '0;
            exl   <= 1'b0;
            ie    <= 1'b0;
            epc_r <= '0;
            cid   <= '0;
`ifdef IRQ_EDGE_EN
            hw_q  <= '0;
`endif
        end else begin
            if (EXLClr) exl <= 1'b0;
            if (cp0Wr && sel == 5'd12) begin
                im  <= wdata[15:10];
                exl <= wdata[1];
                ie  <= wdata[0];
            end
            if (cp0Wr && sel == 5'd14) epc_r <= wdata[31:2];
            // taking an interrupt overrides any same-cycle EXL/EPC write or eret
            if (EXLSet) begin
                exl   <= 1'b1;
                epc_r <= pc[31:2];
                if (cause_id != 3'b111) cid <= cause_id;
            end
`ifdef IRQ_EDGE_EN
            ip   <= (ip & ~clr) | (hwint & ~hw_q);
            hw_q <= hwint;
`else
            ip   <= hwint;
`endif
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scoreboard bench for irq_ctrl, expectations hand-computed for either IP mode
module tb_irq_ctrl;
`ifdef IRQ_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hwint;
    logic        EXLSet, EXLClr, cp0Wr;
    logic [4:0]  sel;
    logic [31:0] wdata, pc, rdata, epc;
    logic        irq;
    logic [2:0]  cause_id;
    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        i;
        logic [2:0]  c;
        logic [31:0] e;
    } exp_t;
    exp_t q[$];
    int total = 0;
    int passed = 0;
    irq_ctrl dut (
        .clk(clk), .rst(rst), .hwint(hwint), .EXLSet(EXLSet), .EXLClr(EXLClr),
        .cp0Wr(cp0Wr), .sel(sel), .wdata(wdata), .pc(pc), .rdata(rdata),
        .epc(epc), .irq(irq), .cause_id(cause_id)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t x;
            x = q.pop_front();
            total++;
            if ({rdata, irq, cause_id, epc} === {x.rd, x.i, x.c, x.e}) passed++;
            else $display("FAIL %s: got rdata=%h irq=%b cause_id=%0d epc=%h, want rdata=%h irq=%b cause_id=%0d epc=%h",
                          x.name, rdata, irq, cause_id, epc, x.rd, x.i, x.c, x.e);
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input string n, input logic [4:0] s, input logic [31:0] rd,
                        input logic i, input logic [2:0] c, input logic [31:0] e);
        exp_t x;
        sel = s;
        x.name = n; x.rd = rd; x.i = i; x.c = c; x.e = e;
        q.push_back(x);
    endtask
    task automatic see(input string n, input logic [4:0] s, input logic [31:0] rd,
                       input logic i, input logic [2:0] c, input logic [31:0] e);
        push(n, s, rd, i, c, e);
        tick();
    endtask
    task automatic wr(input logic [4:0] s, input logic [31:0] d);
        sel = s; wdata = d; cp0Wr = 1'b1;
        tick();
        cp0Wr = 1'b0;
    endtask
    initial begin
        logic [2:0] cidc;
        rst = 1'b1; hwint = '0; EXLSet = 0; EXLClr = 0; cp0Wr = 0; sel = 5'd12; wdata = '0; pc = '0;
        repeat (2) tick();
        see("reset_sr", 12, 32'h0, 0, 7, 0);
        see("reset_cause", 13, 32'h0, 0, 7, 0);
        see("reset_epc", 14, 32'h0, 0, 7, 0);
        rst = 1'b0;
        see("prid", 15, 32'h4D49_5053, 0, 7, 0);
        // enable all sources, then raise hwint[2]
        wr(12, 32'h0000_FC01);
        see("sr_write", 12, 32'h0000_FC01, 0, 7, 0);
        hwint = 6'b000100;
        see("ip_latency", 13, 32'h0, 0, 7, 0);
        see("irq_src2", 13, 32'h0000_1000, 1, 2, 0);
        hwint = 6'b100010;
        see("pre_prio", 13, 32'h0000_1000, 1, 2, 0);
        see("prio_src1", 13, EDGE ? 32'h0000_9800 : 32'h0000_8800, 1, 1, 0);
        EXLSet = 1'b1; pc = 32'h0000_300B;
        tick();
        EXLSet = 1'b0;
        see("exlset_cause", 13, EDGE ? 32'h0000_9004 : 32'h0000_8804, 0, EDGE ? 3'd2 : 3'd1, 32'h0000_3008);
        see("exlset_sr", 12, 32'h0000_FC03, 0, EDGE ? 3'd2 : 3'd1, 32'h0000_3008);
        // set and clear together: set wins
        cidc = EDGE ? 3'd5 : 3'd1;
        EXLSet = 1'b1; EXLClr = 1'b1; pc = 32'h0000_4000;
        tick();
        EXLSet = 1'b0; EXLClr = 1'b0;
        see("set_clr_same", 12, 32'h0000_FC03, 0, cidc, 32'h0000_4000);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        see("eret_reirq", 12, 32'h0000_FC01, 1, cidc, 32'h0000_4000);
        see("eret_cause", 13, EDGE ? 32'h0000_8008 : 32'h0000_8804, 1, cidc, 32'h0000_4000);
        wr(14, 32'h0000_300F);
        see("epc_write", 14, 32'h0000_300C, 1, cidc, 32'h0000_300C);
        wr(13, 32'hFFFF_FFFF);
        see("cause_ro", 13, EDGE ? 32'h0000_8008 : 32'h0000_8804, 1, cidc, 32'h0000_300C);
        wr(15, 32'hFFFF_FFFF);
        see("prid_ro", 15, 32'h4D49_5053, 1, cidc, 32'h0000_300C);
        wr(3, 32'hFFFF_FFFF);
        see("other_sel", 3, 32'h0, 1, cidc, 32'h0000_300C);
        // SR write coinciding with EXLSet: IM/IE from wdata, EXL/EPC from EXLSet
        sel = 5'd12; wdata = 32'h0000_0400; cp0Wr = 1'b1; EXLSet = 1'b1; pc = 32'h0000_5000;
        tick();
        cp0Wr = 1'b0; EXLSet = 1'b0;
        see("wr_with_set_sr", 12, 32'h0000_0402, 0, 7, 32'h0000_5000);
        see("wr_with_set_cause", 13, EDGE ? 32'h0000_0014 : 32'h0000_8804, 0, 7, 32'h0000_5000);
        // held level on hwint[3]
        hwint = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        wr(12, 32'h0000_FC01);
        see("rearm", 12, 32'h0000_FC01, 0, 7, 0);
        hwint = 6'b001000;
        tick();
        see("src3", 13, 32'h0000_2000, 1, 3, 0);
        EXLSet = 1'b1; pc = 32'h0000_6000;
        tick();
        EXLSet = 1'b0;
        see("src3_taken", 13, EDGE ? 32'h0000_000C : 32'h0000_200C, 0, EDGE ? 3'd7 : 3'd3, 32'h0000_6000);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        see("src3_eret", 12, 32'h0000_FC01, !EDGE, EDGE ? 3'd7 : 3'd3, 32'h0000_6000);
        see("src3_held", 13, EDGE ? 32'h0000_000C : 32'h0000_200C, !EDGE, EDGE ? 3'd7 : 3'd3, 32'h0000_6000);
        hwint = '0;
        tick();
        hwint = 6'b001000;
        tick();
        see("src3_reedge", 13, 32'h0000_200C, 1, 3, 32'h0000_6000);
        // async reset while EXL=1 and IP pending
        EXLSet = 1'b1; pc = 32'h0000_7000;
        tick();
        EXLSet = 1'b0; hwint = 6'b000001;
        tick();
        see("exl_pending", 13, 32'h0000_040C, 0, 0, 32'h0000_7000);
        #1 rst = 1'b1;
        push("async_rst_sr", 12, 32'h0, 0, 7, 0);
        @(negedge clk);
        #1;
        push("async_rst_cause", 13, 32'h0, 0, 7, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        if (q.size() != 0) begin
            total += q.size();
            $display("FAIL drain: %0d checks pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port hwint, input, 6, device interrupt requests; bit 0 is highest priority.
REQ-004 SHALL have port EXLSet, input, 1, controller is taking an interrupt this cycle.
REQ-005 SHALL have port EXLClr, input, 1, controller is executing eret.
REQ-006 SHALL have port cp0Wr, input, 1, mtc0 write strobe.
REQ-007 SHALL have port sel, input, 5, CP0 register number for read and write.
REQ-008 SHALL have port wdata, input, 32, mtc0 write data.
REQ-009 SHALL have port pc, input, 32, return address captured into EPC on EXLSet.
REQ-010 SHALL have port rdata, output, 32, mfc0 read data, combinational from sel.
REQ-011 SHALL have port epc, output, 32, current EPC, driven to the eret next-PC path.
REQ-012 SHALL have port irq, output, 1, interrupt request to the controller.
REQ-013 SHALL have port cause_id, output, 3, index of the winning source; 3'b111 when none.

Function
REQ-014 SHALL hold SR (sel 12) with IM = SR[15:10], EXL = SR[1] and IE = SR[0]; all other bits read 0.
REQ-015 SHALL hold Cause (sel 13) with IP = Cause[15:10] and the last taken id in Cause[4:2]; all other bits read 0; Cause is read-only.
REQ-016 SHALL hold EPC (sel 14), and SHALL return PRId (sel 15) as the constant 32'h4D49_5053; PRId is read-only; any other sel SHALL read 32'h0.
REQ-017 SHALL drive irq = |(IP & IM) & IE & ~EXL combinationally from registered state only, with no combinational path from hwint.
REQ-018 SHALL drive cause_id as the lowest index i with IP[i] & IM[i], or 3'b111 if there is none, regardless of IE and EXL.
REQ-019 On EXLSet: EXL <= 1, EPC <= {pc[31:2],2'b00}, Cause[4:2] <= cause_id; if cause_id is 3'b111, Cause[4:2] SHALL be unchanged.
REQ-020 On EXLClr without EXLSet: EXL <= 0; IP, IM and EPC SHALL be unchanged.
REQ-021 Simultaneous EXLSet and EXLClr: EXLSet SHALL win (EXL = 1, EPC captured).
REQ-022 cp0Wr with sel=12 SHALL load IM, EXL and IE from wdata; cp0Wr with sel=14 SHALL load EPC = {wdata[31:2],2'b00}; writes to other sel SHALL be ignored.
REQ-023 cp0Wr in the same cycle as EXLSet: EXL and EPC SHALL take the EXLSet values, while IM and IE SHALL take wdata.
REQ-024 The effects of a write SHALL become visible on rdata, irq and epc in the cycle after the write edge (1-cycle latency).
REQ-025 Once irq is asserted, further irq SHALL be blocked until EXLClr (or an SR write) clears EXL; nesting SHALL NOT occur.

Reset
REQ-026 rst SHALL immediately clear SR, IP, EPC, Cause[4:2] and the edge-history register, giving irq=0, cause_id=3'b111, epc=0 and rdata=0 for sel 12/13/14.
REQ-027 rst asserted mid-interrupt (EXL=1) SHALL drop EXL and any pending IP without completing the interrupt.

Configuration
REQ-028 Macro IRQ_EDGE_EN: when defined, IP[i] SHALL set on a rising edge of hwint[i] (registered hwint 0 then 1) and clear only on EXLSet when cause_id==i; a new edge in the same cycle as the clear SHALL set IP[i] again (set wins).
REQ-029 When IRQ_EDGE_EN is undefined, IP SHALL be level-sensitive: IP <= hwint every cycle, with EXLSet having no effect on IP.

Verification
REQ-030 SR write 32'h0000_FC01, hwint=6'b000100 -> irq=1 and cause_id=2 on the cycle after IP sets.
REQ-031 hwint=6'b100010 with IM all set and IE=1 -> cause_id=1; pulse EXLSet with pc=32'h0000_3008 -> EXL=1, epc=32'h0000_3008, irq=0, rdata(sel 13)[4:2]=1.
REQ-032 EXLSet and EXLClr pulsed in the same cycle -> EXL=1; EXLClr alone next cycle -> EXL=0, irq re-asserts if still pending.
REQ-033 cp0Wr sel=14 wdata=32'h0000_300F -> epc=32'h0000_300C; cp0Wr sel=13 -> Cause unchanged; sel=15 read -> 32'h4D49_5053.
REQ-034 IRQ_EDGE_EN defined, hwint[3] held high -> exactly one interrupt; after EXLSet, IP[3]=0 and no re-trigger until hwint[3] falls and rises again; undefined -> IP[3] stays 1.
REQ-035 rst asserted asynchronously while EXL=1 and IP nonzero -> SR=0, IP=0, irq=0, cause_id=3'b111, without waiting for a clock edge.
